serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart to the combinational ripple adder datapath. It trades WIDTH cycles of latency for one cell of logic.
- Sits on a valid/ready stream: accepts one operand pair, returns one difference/borrow result.

Parameters:
- WIDTH, 3, operand and difference width in bits (legal range 1 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair a/b/bin is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out, 1 iff a < b + bin (unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). The polarity and synchronicity of rst are fixed.
- Reset (rst=1 at a rising edge): state=IDLE, out_valid=0, diff=0, bout=0, busy=0, internal borrow=0, bit counter=0.
  - in_ready is decoded from the state, so it reads 1 after reset.
  - rst has priority over all other inputs.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1 at an edge (accept):
  - Load a and b into internal shift registers, borrow<=bin, counter<=0, go to RUN.
  - The diff register is not cleared on accept.
- RUN: each edge processes the current LSBs x=a_sh[0], y=b_sh[0] with the current borrow br.
  - d = x ^ y ^ br.
  - br_next = (~x & y) | (~x & br) | (y & br).
  - d is shifted into diff from the MSB end (diff <= {d, diff[WIDTH-1:1]}).
  - a_sh and b_sh shift right by one; counter increments.
  - On the edge that processes bit WIDTH-1: bout<=br_next, out_valid<=1, go to DONE.
- Latency: if operands are accepted at edge k, out_valid is first visible after edge k+WIDTH. For WIDTH=3 that is 3 cycles.
- DONE: diff, bout and out_valid are held stable; in_ready=0.
  - When out_ready=1 at an edge: out_valid<=0, go to IDLE.
  - There is no accept on that same edge; the next accept happens no earlier than the following edge. Throughput is one result per WIDTH+2 cycles minimum.
- in_valid in RUN or DONE is ignored; nothing is queued.
- Changes on a, b or bin after the accept edge have no effect.
- out_ready outside DONE is ignored.
- In IDLE, diff and bout retain the last result. Their value is only meaningful while out_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation: no result is emitted and out_valid drops.
- Width rules:
  - Counter is clog2(WIDTH+1) bits.
  - {bout, diff} equals (a - b - bin) taken modulo 2^(WIDTH+1), with bout as the sign/borrow bit.
- WIDTH=1 case: the single RUN edge both processes bit 0 and transitions to DONE.

Test Plan (WIDTH=3):
1. Reset, then a=5, b=2, bin=0 accepted at edge k -> out_valid rises after edge k+3 with diff=3, bout=0. busy=1 from edge k+1 until out_ready is taken.
2. a=2, b=5, bin=0 -> diff=5, bout=1. Then a=0, b=0, bin=1 -> diff=7, bout=1. Then a=7, b=7, bin=0 -> diff=0, bout=0.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid with result a=6, b=1 (diff=5) -> diff=5, bout=0 and out_valid stay stable, in_ready=0.
   - Pulse in_valid with a=1, b=1 during the hold -> ignored; the next result corresponds only to operands presented in IDLE.
4. Operand change: accept a=4, b=1, then drive a=0, b=7 during RUN -> result diff=3, bout=0.
5. Reset mid-RUN: assert rst one cycle after accept of a=5, b=3 -> out_valid never rises, in_ready=1 after the reset edge, diff=0. A subsequent a=6, b=1 -> diff=5, bout=0.
6. Exhaustive sweep of all 128 (a, b, bin) combinations with random in_valid gaps and random out_ready stalls. Each result is checked against the model {bout, diff} = (a - b - bin) mod 16, with exact 3-cycle latency from accept to out_valid.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - bin, LSB first, one full-subtractor cell
// with a registered borrow, wrapped in a single-entry valid/ready handshake.
module serial_subtractor #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             vld_q, vld_d;

    logic             x, y, d, br_next;
    logic [WIDTH-1:0] diff_shift;

    assign x       = a_q[0];
    assign y       = b_q[0];
    assign d       = x ^ y ^ br_q;
    assign br_next = (~x & y) | (~x & br_q) | (y & br_q);

    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_shift = d;
        end else begin : g_wn
            assign diff_shift = {d, diff_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = diff_shift;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = br_next;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=3: expected {bout,diff}
// is queued at accept and compared when out_valid appears.
module tb_serial_subtractor;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [W:0] sb_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive one operand pair for a single edge and queue the expected result.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        logic [W:0] e;
        a        = av;
        b        = bv;
        bin      = bv_in;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bv_in};
        sb_q.push_back(e);
    endtask

    // Cycles from the accept edge until out_valid; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b bout=%b diff=%0d want rdy=1 vld=0 busy=0 bout=0 diff=0",
                     in_ready, out_valid, busy, bout, diff);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [W:0] e;
        send(3'd5, 3'd2, 1'b0);
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: got busy=%b rdy=%b want busy=1 rdy=0", busy, in_ready);
        end
        wait_valid(lat);
        lat = (lat < 0) ? lat : lat + 1;
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        e = sb_q.pop_front();
        total++;
        if ({bout, diff} !== e) begin
            bad++;
            $display("FAIL basic_result: got bout=%b diff=%0d want bout=%b diff=%0d", bout, diff, e[W], e[W-1:0]);
        end
        release_result();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release: got vld=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] ta[3] = '{3'd2, 3'd0, 3'd7};
        logic [W-1:0] tb_[3] = '{3'd5, 3'd0, 3'd7};
        logic         tc[3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   want[3] = '{4'b1101, 4'b1111, 4'b0000};
        int lat;
        logic [W:0] e;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb_[i], tc[i]);
            wait_valid(lat);
            e = sb_q.pop_front();
            total++;
            if ({bout, diff} !== e || e !== want[i] || lat !== 3) begin
                bad++;
                $display("FAIL pattern_%0d: got bout=%b diff=%0d lat=%0d want bout=%b diff=%0d lat=3",
                         i, bout, diff, lat, want[i][W], want[i][W-1:0]);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W:0] e;
        send(3'd6, 3'd1, 1'b0);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                a = 3'd1; b = 3'd1; bin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++;
            if ({out_valid, in_ready, bout, diff} !== {1'b1, 1'b0, 1'b0, 3'd5}) begin
                bad++;
                $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b bout=%b diff=%0d want vld=1 rdy=0 bout=0 diff=5",
                         c, out_valid, in_ready, bout, diff);
            end
        end
        e = sb_q.pop_front();
        total++;
        if ({bout, diff} !== e) begin
            bad++;
            $display("FAIL hold_result: got bout=%b diff=%0d want bout=%b diff=%0d", bout, diff, e[W], e[W-1:0]);
        end
        release_result();
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ignored_pulse: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        send(3'd3, 3'd1, 1'b0);
        wait_valid(lat);
        e = sb_q.pop_front();
        total++;
        if ({bout, diff} !== e || sb_q.size() != 0) begin
            bad++;
            $display("FAIL after_hold: got bout=%b diff=%0d want bout=%b diff=%0d", bout, diff, e[W], e[W-1:0]);
        end
        release_result();
    endtask

    task automatic test_operand_change();
        int lat;
        logic [W:0] e;
        send(3'd4, 3'd1, 1'b0);
        a = 3'd0; b = 3'd7; bin = 1'b1;
        wait_valid(lat);
        e = sb_q.pop_front();
        total++;
        if ({bout, diff} !== e || lat !== 3) begin
            bad++;
            $display("FAIL operand_change: got bout=%b diff=%0d lat=%0d want bout=%b diff=%0d lat=3",
                     bout, diff, lat, e[W], e[W-1:0]);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic rose;
        logic [W:0] e;
        a = 3'd5; b = 3'd3; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_mid_run: got rdy=%b vld=%b diff=%0d want rdy=1 vld=0 diff=0", in_ready, out_valid, diff);
        end
        rose = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            rose = rose | out_valid;
        end
        total++;
        if (rose !== 1'b0) begin
            bad++;
            $display("FAIL aborted_result: got out_valid rose=%b want 0", rose);
        end
        send(3'd6, 3'd1, 1'b0);
        wait_valid(lat);
        e = sb_q.pop_front();
        total++;
        if ({bout, diff} !== e || e !== 4'b0101) begin
            bad++;
            $display("FAIL after_reset: got bout=%b diff=%0d want bout=0 diff=5", bout, diff);
        end
        release_result();
    endtask

    task automatic test_sweep();
        int lat;
        int stall;
        logic [W:0] e;
        logic [6:0] v;
        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(v[2:0], v[5:3], v[6]);
            wait_valid(lat);
            total++;
            if (lat !== 3) begin
                bad++;
                $display("FAIL sweep_latency a=%0d b=%0d bin=%b: got %0d want 3", v[2:0], v[5:3], v[6], lat);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if ({out_valid, bout, diff} !== {1'b1, e}) begin
                bad++;
                $display("FAIL sweep_result a=%0d b=%0d bin=%b: got vld=%b bout=%b diff=%0d want vld=1 bout=%b diff=%0d",
                         v[2:0], v[5:3], v[6], out_valid, bout, diff, e[W], e[W-1:0]);
            end
            release_result();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
